// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 UART receiver with a 2-flop input synchronizer, mid-bit
// sampling, one-cycle valid/frame-error pulses and break (held-low) handling.
module uart_rx_8n1 #(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rx_serial,
  output logic [7:0] UART_Rx,
  output logic       Flag_Rx,
  output logic       Frame_err,
  output logic       Rx_busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // Start bit is checked at its middle; data/stop bits one full bit later,
  // so every later sample also lands mid-bit.
  localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(BAUD_DIV - 1);

  logic        rx_meta_q, rx_s_q;
  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        flag_q, flag_d;
  logic        ferr_q, ferr_d;

  // Two-flop synchronizer; idles at 1 so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= Rx_serial;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State, counters, shift register and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      flag_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic; the baud counter is zeroed on every state transition.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    flag_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (baud_q == HALF_M1) begin
          baud_d  = '0;
          // A line back high at mid-start is a glitch: drop it silently.
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (baud_q == FULL_M1) begin
          baud_d  = '0;
          shift_d = {rx_s_q, shift_q[7:1]};  // LSB arrives first
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_q == FULL_M1) begin
          baud_d = '0;
          if (rx_s_q) begin
            // Leaving mid-stop-bit lets a back-to-back start bit be caught.
            data_d  = shift_q;
            flag_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Wait for the line to recover so a held-low line is not re-decoded.
        baud_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  assign UART_Rx   = data_q;
  assign Flag_Rx   = flag_q;
  assign Frame_err = ferr_q;
  assign Rx_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1 at BAUD_DIV=16 plus full byte sweeps at 8 and 17.
module tb_uart_rx_8n1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic r16 = 1'b1, r8 = 1'b1, r17 = 1'b1;
  logic [7:0] d16, d8, d17;
  logic f16, f8, f17, e16, e8, e17, b16, b8, b17;

  int errors = 0;
  int checks = 0;
  int flags16 = 0, flags8 = 0, flags17 = 0;
  int ferrs16 = 0, ferrs8 = 0, ferrs17 = 0;
  logic [7:0] q16[$], q8[$], q17[$];

  always #5 clk = ~clk;

  uart_rx_8n1 #(.BAUD_DIV(16)) u16 (.clk(clk), .rst(rst), .Rx_serial(r16), .UART_Rx(d16),
    .Flag_Rx(f16), .Frame_err(e16), .Rx_busy(b16));
  uart_rx_8n1 #(.BAUD_DIV(8)) u8 (.clk(clk), .rst(rst), .Rx_serial(r8), .UART_Rx(d8),
    .Flag_Rx(f8), .Frame_err(e8), .Rx_busy(b8));
  uart_rx_8n1 #(.BAUD_DIV(17)) u17 (.clk(clk), .rst(rst), .Rx_serial(r17), .UART_Rx(d17),
    .Flag_Rx(f17), .Frame_err(e17), .Rx_busy(b17));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors: pop expected byte on each valid pulse.
  always @(negedge clk) begin
    if (f16) begin
      flags16++;
      chk("sb16_nonempty", 32'(q16.size() > 0), 32'd1);
      if (q16.size() > 0) chk("sb16_data", 32'(d16), 32'(q16.pop_front()));
    end
    if (e16) ferrs16++;
    if (f16 || e16) chk("excl16", 32'(f16 && e16), 32'd0);
  end

  always @(negedge clk) begin
    if (f8) begin
      flags8++;
      chk("sb8_nonempty", 32'(q8.size() > 0), 32'd1);
      if (q8.size() > 0) chk("sb8_data", 32'(d8), 32'(q8.pop_front()));
    end
    if (e8) ferrs8++;
  end

  always @(negedge clk) begin
    if (f17) begin
      flags17++;
      chk("sb17_nonempty", 32'(q17.size() > 0), 32'd1);
      if (q17.size() > 0) chk("sb17_data", 32'(d17), 32'(q17.pop_front()));
    end
    if (e17) ferrs17++;
  end

  task automatic set_line(input int sel, input logic v);
    case (sel)
      0: r16 = v;
      1: r8  = v;
      default: r17 = v;
    endcase
  endtask

  // Drive a level then wait n falling edges; callers stay on negedges.
  task automatic hold(input int sel, input logic v, input int n);
    set_line(sel, v);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int sel, input int div, input logic [7:0] b, input logic stopv);
    hold(sel, 1'b0, div);
    for (int i = 0; i < 8; i++) hold(sel, b[i], div);
    hold(sel, stopv, div);
    set_line(sel, 1'b1);
  endtask

  initial begin
    int fl, fe;
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_data", 32'(d16), 32'h00);
    chk("rst_flag", 32'(f16), 32'd0);
    chk("rst_ferr", 32'(e16), 32'd0);
    chk("rst_busy", 32'(b16), 32'd0);
    repeat (4) @(negedge clk);

    // Single valid frame
    q16.push_back(8'hFE);
    send(0, 16, 8'hFE, 1'b1);
    repeat (32) @(negedge clk);
    chk("fe_data", 32'(d16), 32'hFE);
    chk("fe_flags", 32'(flags16), 32'd1);
    chk("fe_ferrs", 32'(ferrs16), 32'd0);

    // Back-to-back frames, no idle gap
    foreach (q16[i]) ; // queue drained by now
    q16.push_back(8'h06); q16.push_back(8'h04); q16.push_back(8'hA5);
    send(0, 16, 8'h06, 1'b1);
    send(0, 16, 8'h04, 1'b1);
    send(0, 16, 8'hA5, 1'b1);
    repeat (32) @(negedge clk);
    chk("b2b_flags", 32'(flags16), 32'd4);
    chk("b2b_data", 32'(d16), 32'hA5);
    chk("b2b_q", 32'(q16.size()), 32'd0);

    // 4-cycle low glitch on an idle line
    set_line(0, 1'b0);
    repeat (3) @(negedge clk);
    chk("gl_busy_hi", 32'(b16), 32'd1);
    @(negedge clk);
    set_line(0, 1'b1);
    repeat (20) @(negedge clk);
    chk("gl_busy_lo", 32'(b16), 32'd0);
    chk("gl_flags", 32'(flags16), 32'd4);
    chk("gl_ferrs", 32'(ferrs16), 32'd0);
    chk("gl_data", 32'(d16), 32'hA5);

    // Stop bit low, then held low 40 bit times (break)
    send(0, 16, 8'h3C, 1'b0);
    set_line(0, 1'b0);
    repeat (20 * 16) @(negedge clk);
    chk("brk_busy_mid", 32'(b16), 32'd1);
    repeat (20 * 16) @(negedge clk);
    chk("brk_busy_end", 32'(b16), 32'd1);
    chk("brk_ferrs", 32'(ferrs16), 32'd1);
    chk("brk_flags", 32'(flags16), 32'd4);
    chk("brk_data", 32'(d16), 32'hA5);
    hold(0, 1'b1, 32);
    chk("brk_release", 32'(b16), 32'd0);
    q16.push_back(8'h55);
    send(0, 16, 8'h55, 1'b1);
    repeat (32) @(negedge clk);
    chk("brk_next_data", 32'(d16), 32'h55);
    chk("brk_next_flags", 32'(flags16), 32'd5);
    chk("brk_ferrs_once", 32'(ferrs16), 32'd1);

    // Reset mid-frame during data bit 4 of 8'hFF
    hold(0, 1'b0, 16);
    for (int i = 0; i < 4; i++) hold(0, 1'b1, 16);
    hold(0, 1'b1, 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", 32'(b16), 32'd0);
    chk("mrst_data", 32'(d16), 32'h00);
    hold(0, 1'b1, 16 * 6);
    chk("mrst_flags", 32'(flags16), 32'd5);
    chk("mrst_data_hold", 32'(d16), 32'h00);
    q16.push_back(8'h81);
    send(0, 16, 8'h81, 1'b1);
    repeat (32) @(negedge clk);
    chk("mrst_next_data", 32'(d16), 32'h81);
    chk("mrst_next_flags", 32'(flags16), 32'd6);

    // Full byte sweeps at BAUD_DIV=8 and 17
    for (int b = 0; b < 256; b++) begin
      q8.push_back(8'(b));
      send(1, 8, 8'(b), 1'b1);
    end
    repeat (32) @(negedge clk);
    for (int b = 0; b < 256; b++) begin
      q17.push_back(8'(b));
      send(2, 17, 8'(b), 1'b1);
    end
    repeat (40) @(negedge clk);
    fl = flags8; fe = ferrs8;
    chk("sw8_flags", 32'(fl), 32'd256);
    chk("sw8_ferrs", 32'(fe), 32'd0);
    chk("sw8_q", 32'(q8.size()), 32'd0);
    chk("sw17_flags", 32'(flags17), 32'd256);
    chk("sw17_ferrs", 32'(ferrs17), 32'd0);
    chk("sw17_q", 32'(q17.size()), 32'd0);
    chk("final_q16", 32'(q16.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_8n1.md
UART_RX_8N1 -- requirements
Module: uart_rx_8n1

Interface
REQ-001 SHALL provide parameter BAUD_DIV, default 5208, clock cycles per bit (50 MHz / 9600 baud); legal range 8..65535.
REQ-002 SHALL provide port clk, input, 1, single clock for all logic; one clock.
REQ-003 SHALL provide port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL provide port Rx_serial, input, 1, asynchronous serial line (8N1, idle high).
REQ-005 SHALL provide port UART_Rx, output, 8, last correctly received byte.
REQ-006 SHALL provide port Flag_Rx, output, 1, one-cycle pulse: new valid byte on UART_Rx.
REQ-007 SHALL provide port Frame_err, output, 1, one-cycle pulse: stop bit sampled low.
REQ-008 SHALL provide port Rx_busy, output, 1, high whenever state is not IDLE.

Function
REQ-009 SHALL pass Rx_serial through a 2-flop synchronizer; all decisions use the synchronized value (rx_s); the synchronizer flops reset to 1.
REQ-010 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-011 Bit counter: baud counter 16 bits, counts 0..BAUD_DIV-1, cleared on every state entry; bit index 3 bits, counts 0..7.
REQ-012 IDLE: rx_s=0 -> START, baud counter cleared; otherwise stay.
REQ-013 START: when baud counter reaches BAUD_DIV/2-1 (integer divide), sample rx_s; 0 -> DATA, baud counter cleared; 1 -> IDLE (glitch rejected, no flag, no error).
REQ-014 DATA: when baud counter reaches BAUD_DIV-1, sample rx_s into the shift register, LSB first (bit index 0 = D0), clear baud counter, increment bit index; after bit index 7 is sampled -> STOP.
REQ-015 STOP: when baud counter reaches BAUD_DIV-1, sample rx_s; 1 -> UART_Rx loaded with the shift register, Flag_Rx=1 for exactly that next cycle, -> IDLE.
REQ-016 STOP sample 0 -> Frame_err=1 for one cycle, UART_Rx unchanged, Flag_Rx stays 0, -> BREAK.
REQ-017 BREAK: stay until rx_s=1, then -> IDLE; a held-low line SHALL NOT be decoded as new start bits.
REQ-018 UART_Rx SHALL hold its value until the next valid frame; it never shows partial data.
REQ-019 Flag_Rx and Frame_err SHALL never be high in the same cycle; each pulse lasts exactly one clk.
REQ-020 Back-to-back frames, i.e. a start bit immediately after the stop bit, SHALL be received without loss, because IDLE is re-entered mid-stop-bit.
REQ-021 Latency: Flag_Rx rises 1 cycle after the stop-bit sample point, which is about 9.5 bit times + 2 synchronizer cycles after the start-bit falling edge.
REQ-022 Any state value that is not defined SHALL return to IDLE on the next cycle.

Reset
REQ-023 rst=1 at a clk edge SHALL force, in any state including mid-frame: state=IDLE, counters=0, shift register=0, UART_Rx=8'h00, Flag_Rx=0, Frame_err=0, Rx_busy=0, synchronizer=1.
REQ-024 A frame that is in progress when reset is applied SHALL be discarded, with no flag; reception restarts on the first falling edge after rst deasserts.

Verification (BAUD_DIV=16)
REQ-025 Send 8'hFE as a valid 8N1 frame -> exactly one Flag_Rx pulse, UART_Rx=8'hFE, Frame_err never high.
REQ-026 Send 8'h06, 8'h04, 8'hA5 back-to-back with no idle gap -> three Flag_Rx pulses, UART_Rx values 06, 04, A5 in that order.
REQ-027 Send a low glitch of 4 cycles on an idle line -> returns to IDLE after the START check, no Flag_Rx, no Frame_err, UART_Rx unchanged.
REQ-028 Send frame 8'h3C with the stop bit driven low, then hold the line low for 40 bit times, then release -> one Frame_err pulse, no Flag_Rx, UART_Rx keeps its prior value, state stays BREAK until release, then a following frame 8'h55 gives Flag_Rx with UART_Rx=8'h55.
REQ-029 Assert rst for 1 cycle during DATA bit 4 of frame 8'hFF -> no Flag_Rx for that frame, UART_Rx=8'h00, Rx_busy=0; the next frame 8'h81 is received correctly.
REQ-030 Sweep all 256 byte values with BAUD_DIV=8 and BAUD_DIV=17 -> every byte received exactly, one Flag_Rx per frame.
